simd_mode_sched: RTL

- Sequencer and arbiter for the 64-lane SIMD array.
- Four requesters (MAC, DIV, EXP, LOG; index = array mode code 0..3) compete for the shared array. Winners are picked round-robin.
- Drives the array's 2-bit mode select, enable and accumulator-clear, and counts the unary run length of each operation.
- Inserts flush gap cycles whenever the mode changes, so no partial bitstream leaks between datapaths.

---
 rtl/simd_mode_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/simd_mode_sched.sv
// Round-robin arbiter and mode sequencer for the 64-lane SIMD array.
// Grants one of four requesters and inserts flush gap cycles on every mode change.
module simd_mode_sched #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned SWITCH_GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*CNT_W-1:0] req_len,
  input  logic               abort,
  output logic [3:0]         gnt,
  output logic [1:0]         mode,
  output logic               arr_en,
  output logic               arr_clr,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_mode
);

  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         rr_last_q, rr_last_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               arr_en_q, arr_en_d;
  logic               arr_clr_q, arr_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         done_mode_q, done_mode_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;
  logic [CNT_W-1:0]   win_len;

  // Scan from rr_last+1 upward; the lowest offset with a request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    win_len   = '0;
    cand      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = 2'(rr_last_q + 2'(i) + 2'd1);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_len   = req_len[int'(cand)*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rr_last_d = rr_last_q;
    len_d     = len_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gnt_d     = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (!abort && win_found) begin
          gnt_d     = 4'b0001 << win_idx;
          rr_last_d = win_idx;
          len_d     = win_len;
          run_cnt_d = win_len;
          if (win_idx != mode_q) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_W'(SWITCH_GAP);
            mode_d    = win_idx;
          end else if (win_len != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = (len_q != '0) ? S_RUN : S_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (run_cnt_q <= CNT_W'(1)) begin
          run_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    arr_en_d    = (state_d == S_RUN);
    arr_clr_d   = (state_d == S_RUN) && (state_q != S_RUN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    done_mode_d = done_d ? mode_d : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      rr_last_q   <= 2'd3;
      len_q       <= '0;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      gnt_q       <= 4'b0000;
      arr_en_q    <= 1'b0;
      arr_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_mode_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rr_last_q   <= rr_last_d;
      len_q       <= len_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      gnt_q       <= gnt_d;
      arr_en_q    <= arr_en_d;
      arr_clr_q   <= arr_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_mode_q <= done_mode_d;
    end
  end

  assign gnt       = gnt_q;
  assign mode      = mode_q;
  assign arr_en    = arr_en_q;
  assign arr_clr   = arr_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_mode = done_mode_q;

endmodule
